// File: rtl/pcm_pkg.sv
// Shared definitions for the multiplexed ADPCM address demultiplexer.
// Holds the synchroniser depth, the latency counter width and the channel FSM states.
package pcm_pkg;

  localparam int SYNC_DEPTH = 2;
  localparam int CNT_W      = 4;

  typedef enum logic {
    WAIT_LO = 1'b0,
    WAIT_HI = 1'b1
  } pcm_state_t;

endpackage

// File: rtl/pcm_addr_chan.sv
// One multiplexed ADPCM address channel: MPX synchroniser, low/high phase FSM,
// read-latency down-counter and registered ROM return byte.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   WAIT_LO | idle; expecting an MPX rise that carries the low address half
//   WAIT_HI | low half held; expecting an MPX fall that carries the high half
module pcm_addr_chan
  import pcm_pkg::*;
#(
  parameter  int SIDE_W = 4,
  parameter  int RD_LAT = 4,
  localparam int HALF_W = 8 + SIDE_W,
  localparam int AW     = 2 * HALF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mpx,
  input  logic [7:0]        ad_in,
  input  logic [SIDE_W-1:0] side,
  input  logic              oe_n,
  input  logic [7:0]        rom_data,
  output logic [AW-1:0]     addr,
  output logic              addr_stb,
  output logic [7:0]        ad_out,
  output logic              drv_en,
  output logic              seq_err
);

  // RD_LAT must lie in 1..15 so it fits the counter and never loads as idle.
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RD_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_DEPTH-1:0]             mpx_sync;
  logic                              mpx_hist;
  logic [SYNC_DEPTH:0]               sync_vld;
  logic [SYNC_DEPTH-1:0][HALF_W-1:0] dat_pipe;
  logic                              mpx_now;

  logic              ev_rise;
  logic              ev_fall;
  logic [HALF_W-1:0] ev_dat;

  pcm_state_t state_q;
  pcm_state_t state_d;
  logic       lo_ld;
  logic       addr_ld;
  logic       err_set;

  logic [HALF_W-1:0] lo;
  logic [CNT_W-1:0]  cnt;
  logic              dvalid;

  assign mpx_now = mpx_sync[SYNC_DEPTH-1];

  // Data rides alongside MPX so each phase sees the bus value from the edge
  // where the first sync stage picked up the new level. sync_vld stops the
  // first samples after reset from being mistaken for an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mpx_sync <= '0;
      mpx_hist <= 1'b0;
      sync_vld <= '0;
      dat_pipe <= '0;
      ev_rise  <= 1'b0;
      ev_fall  <= 1'b0;
      ev_dat   <= '0;
    end else begin
      mpx_sync <= {mpx_sync[SYNC_DEPTH-2:0], mpx};
      mpx_hist <= mpx_now;
      sync_vld <= {sync_vld[SYNC_DEPTH-1:0], 1'b1};
      dat_pipe <= {dat_pipe[SYNC_DEPTH-2:0], {side, ad_in}};
      ev_rise  <= sync_vld[SYNC_DEPTH] & mpx_now & ~mpx_hist;
      ev_fall  <= sync_vld[SYNC_DEPTH] & ~mpx_now & mpx_hist;
      ev_dat   <= dat_pipe[SYNC_DEPTH-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= WAIT_LO;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    lo_ld   = 1'b0;
    addr_ld = 1'b0;
    err_set = 1'b0;
    if (ev_rise) begin
      lo_ld   = 1'b1;
      state_d = WAIT_HI;
    end else if (ev_fall) begin
      if (state_q == WAIT_HI) begin
        addr_ld = 1'b1;
        state_d = WAIT_LO;
      end else begin
        err_set = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo       <= '0;
      addr     <= '0;
      addr_stb <= 1'b0;
      seq_err  <= 1'b0;
    end else begin
      addr_stb <= addr_ld;
      seq_err  <= seq_err | err_set;
      if (lo_ld)   lo   <= ev_dat;
      if (addr_ld) addr <= {ev_dat, lo};
    end
  end

  // A rise landing on the same edge the counter expires wins: capture dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      ad_out <= '0;
      dvalid <= 1'b0;
    end else if (ev_rise) begin
      cnt    <= '0;
      dvalid <= 1'b0;
    end else if (addr_ld) begin
      cnt <= LAT_LOAD;
    end else if (cnt == CNT_ONE) begin
      cnt    <= '0;
      ad_out <= rom_data;
      dvalid <= 1'b1;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_ONE;
    end
  end

  // Left combinational so the bus can be released in the same cycle nOE rises.
  assign drv_en = dvalid & ~oe_n;

endmodule

// File: rtl/pcm_addr_demux.sv
// Demultiplexes NCH independent ADPCM address buses into full V ROM addresses
// and returns the ROM byte after a fixed read latency.
module pcm_addr_demux
  import pcm_pkg::*;
#(
  parameter  int NCH    = 2,
  parameter  int SIDE_W = 4,
  parameter  int RD_LAT = 4,
  localparam int AW     = 2 * (8 + SIDE_W)
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [NCH-1:0]          MPX,
  input  logic [NCH*8-1:0]        AD_IN,
  input  logic [NCH*SIDE_W-1:0]   SIDE,
  input  logic [NCH-1:0]          nOE,
  input  logic [NCH*8-1:0]        ROM_DATA,
  output logic [NCH*AW-1:0]       ADDR,
  output logic [NCH-1:0]          ADDR_STB,
  output logic [NCH*8-1:0]        AD_OUT,
  output logic [NCH-1:0]          DRV_EN,
  output logic [NCH-1:0]          SEQ_ERR
);

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    pcm_addr_chan #(
      .SIDE_W (SIDE_W),
      .RD_LAT (RD_LAT)
    ) u_chan (
      .clk      (CLK),
      .rst      (RESET),
      .mpx      (MPX[c]),
      .ad_in    (AD_IN[8*c +: 8]),
      .side     (SIDE[SIDE_W*c +: SIDE_W]),
      .oe_n     (nOE[c]),
      .rom_data (ROM_DATA[8*c +: 8]),
      .addr     (ADDR[AW*c +: AW]),
      .addr_stb (ADDR_STB[c]),
      .ad_out   (AD_OUT[8*c +: 8]),
      .drv_en   (DRV_EN[c]),
      .seq_err  (SEQ_ERR[c])
    );
  end

endmodule

// File: tb/tb_pcm_addr_demux.sv
// Directed bench for pcm_addr_demux: capture latency, read return, sequence
// errors, abort on re-rise, channel independence and mid-cycle reset.
module tb_pcm_addr_demux;

  localparam int NCH    = 2;
  localparam int SIDE_W = 4;
  localparam int RD_LAT = 4;
  localparam int AW     = 24;

  logic                  CLK = 1'b0;
  logic                  RESET;
  logic [NCH-1:0]        MPX;
  logic [NCH*8-1:0]      AD_IN;
  logic [NCH*SIDE_W-1:0] SIDE;
  logic [NCH-1:0]        nOE;
  logic [NCH*8-1:0]      ROM_DATA;
  logic [NCH*AW-1:0]     ADDR;
  logic [NCH-1:0]        ADDR_STB;
  logic [NCH*8-1:0]      AD_OUT;
  logic [NCH-1:0]        DRV_EN;
  logic [NCH-1:0]        SEQ_ERR;

  int checks = 0;
  int errors = 0;
  int stb_cnt [NCH] = '{0, 0};
  int s0, s1;

  pcm_addr_demux #(.NCH(NCH), .SIDE_W(SIDE_W), .RD_LAT(RD_LAT)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .MPX      (MPX),
    .AD_IN    (AD_IN),
    .SIDE     (SIDE),
    .nOE      (nOE),
    .ROM_DATA (ROM_DATA),
    .ADDR     (ADDR),
    .ADDR_STB (ADDR_STB),
    .AD_OUT   (AD_OUT),
    .DRV_EN   (DRV_EN),
    .SEQ_ERR  (SEQ_ERR)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    for (int c = 0; c < NCH; c++)
      if (ADDR_STB[c] === 1'b1) stb_cnt[c] = stb_cnt[c] + 1;
  end

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic drive(input int c, input logic m, input logic [3:0] s, input logic [7:0] a);
    MPX[c]           = m;
    SIDE[4*c +: 4]   = s;
    AD_IN[8*c +: 8]  = a;
  endtask

  initial begin
    RESET = 1'b1; MPX = 2'b10; AD_IN = '0; SIDE = '0; nOE = 2'b11; ROM_DATA = '0;
    tick(3);
    chk("rst_addr", ADDR, 48'h0);
    chk("rst_stb", ADDR_STB, 2'b00);
    chk("rst_adout", AD_OUT, 16'h0);
    chk("rst_drv", DRV_EN, 2'b00);
    chk("rst_err", SEQ_ERR, 2'b00);
    RESET = 1'b0;
    tick(4);

    // ch1 was high at reset release: its fall is out of order
    s1 = stb_cnt[1];
    MPX[1] = 1'b0;
    tick(6);
    chk("oo_err", SEQ_ERR, 2'b10);
    chk("oo_addr1", ADDR[47:24], 24'h0);
    chk("oo_stb1", stb_cnt[1] - s1, 0);

    // ch0 normal capture and read return
    ROM_DATA[7:0] = 8'h5A; nOE[0] = 1'b0;
    drive(0, 1'b1, 4'h3, 8'h45);
    tick(6);
    chk("pre_drv", DRV_EN[0], 1'b0);
    s0 = stb_cnt[0];
    drive(0, 1'b0, 4'hA, 8'hBC);
    tick(3);
    chk("lat_early_stb", ADDR_STB[0], 1'b0);
    chk("lat_early_addr", ADDR[23:0], 24'h0);
    tick(1);
    chk("addr0", ADDR[23:0], 24'hABC345);
    chk("stb0", ADDR_STB[0], 1'b1);
    tick(1);
    chk("stb0_1cyc", ADDR_STB[0], 1'b0);
    tick(2);
    chk("rd_early_adout", AD_OUT[7:0], 8'h00);
    chk("rd_early_drv", DRV_EN[0], 1'b0);
    tick(1);
    chk("rd_adout", AD_OUT[7:0], 8'h5A);
    chk("rd_drv", DRV_EN[0], 1'b1);
    chk("stb0_count", stb_cnt[0] - s0, 1);
    nOE[0] = 1'b1;
    #1;
    chk("noe_drv", DRV_EN[0], 1'b0);

    // re-rise reaches the FSM on the very edge the counter expires
    tick(1);
    nOE[0] = 1'b0; ROM_DATA[7:0] = 8'hC3;
    drive(0, 1'b1, 4'h7, 8'h11);
    tick(6);
    chk("ab_pre_drv", DRV_EN[0], 1'b0);
    drive(0, 1'b0, 4'h2, 8'h22);
    tick(4);
    chk("ab_addr", ADDR[23:0], 24'h222711);
    chk("ab_stb", ADDR_STB[0], 1'b1);
    drive(0, 1'b1, 4'h0, 8'h00);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk("ab_drv", DRV_EN[0], 1'b0);
    end
    chk("ab_adout", AD_OUT[7:0], 8'h5A);
    drive(0, 1'b0, 4'h0, 8'h00);
    tick(8);

    // both channels together, different addresses
    s0 = stb_cnt[0]; s1 = stb_cnt[1];
    ROM_DATA[15:8] = 8'h77;
    drive(0, 1'b1, 4'h4, 8'h56);
    drive(1, 1'b1, 4'hC, 8'hBA);
    tick(5);
    drive(0, 1'b0, 4'h1, 8'h23);
    drive(1, 1'b0, 4'hF, 8'hED);
    tick(4);
    chk("cc_addr0", ADDR[23:0], 24'h123456);
    chk("cc_addr1", ADDR[47:24], 24'hFEDCBA);
    chk("cc_stb", ADDR_STB, 2'b11);
    tick(2);
    chk("cc_err", SEQ_ERR, 2'b10);
    chk("cc_cnt0", stb_cnt[0] - s0, 1);
    chk("cc_cnt1", stb_cnt[1] - s1, 1);
    tick(2);
    chk("cc_adout", AD_OUT, 16'h77C3);
    chk("cc_drv", DRV_EN, 2'b01);

    // reset between rise and fall
    drive(0, 1'b1, 4'h9, 8'h99);
    tick(5);
    RESET = 1'b1;
    #1;
    chk("mr_addr", ADDR, 48'h0);
    chk("mr_stb", ADDR_STB, 2'b00);
    chk("mr_adout", AD_OUT, 16'h0);
    chk("mr_drv", DRV_EN, 2'b00);
    chk("mr_err", SEQ_ERR, 2'b00);
    tick(2);
    RESET = 1'b0;
    tick(4);
    drive(0, 1'b0, 4'h5, 8'h55);
    tick(6);
    chk("mr_seq_err", SEQ_ERR, 2'b01);
    chk("mr_addr_after", ADDR[23:0], 24'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
